// File: rtl/des_key_sched_iter.sv
// Iterative DES/TDES round-key generator: one 48-bit PC-2 key per accepted beat.
// Handshake: a beat transfers on a clock edge where rk_valid && rk_ready; in_valid/in_ready likewise.
module des_key_sched_iter #(
  parameter int NUM_KEYS     = 1,
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [64*NUM_KEYS-1:0]  in_key,
  input  logic                    in_decrypt,
  input  logic                    in_abort,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic [47:0]             rk_data,
  output logic [3:0]              rk_round,
  output logic [1:0]              rk_key_sel,
  output logic                    rk_dec,
  output logic                    rk_last,
  output logic                    parity_err,
  output logic                    busy
);

  localparam int KW = 64 * NUM_KEYS;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Bit i set means round i+1 shifts by two; rounds 1, 2, 9 and 16 shift by one.
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic parity_ok(input logic [KW-1:0] k);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8 * NUM_KEYS; i++)
      if ((^k[8*i +: 8]) == 1'b0) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [63:0] get_key(input logic [KW-1:0] keys, input logic [1:0] sel);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (sel == 2'(k)) r = keys[64*k +: 64];
    return r;
  endfunction

  // Returns {decrypt_pass, key_sel} for pass p; TDES runs EDE, reversed for decrypt.
  function automatic logic [2:0] pass_cfg(input logic [1:0] p, input logic jd);
    if (NUM_KEYS == 1) return {jd, 2'd0};
    else if (!jd)      return {p == 2'd1, p};
    else               return {p != 2'd1, 2'd2 - p};
  endfunction

  // Decrypt passes start unrotated: a full 28-bit rotation lands on K16.
  function automatic logic [55:0] load_cd(input logic [63:0] key, input logic dec);
    logic [55:0] cd0;
    cd0 = pc1(key);
    return dec ? cd0 : {rotl(cd0[55:28], 1'b0), rotl(cd0[27:0], 1'b0)};
  endfunction

  state_t          state_q, state_d;
  logic [55:0]     cd_q, cd_d;
  logic [3:0]      round_q, round_d;
  logic [1:0]      pass_q, pass_d;
  logic [KW-1:0]   keys_q, keys_d;
  logic            jdec_q, jdec_d;
  logic [1:0]      sel_q, sel_d;
  logic            pdec_q, pdec_d;
  logic            perr_q, perr_d;
  logic [2:0]      cfg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      round_q <= '0;
      pass_q  <= '0;
      keys_q  <= '0;
      jdec_q  <= 1'b0;
      sel_q   <= '0;
      pdec_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      pass_q  <= pass_d;
      keys_q  <= keys_d;
      jdec_q  <= jdec_d;
      sel_q   <= sel_d;
      pdec_q  <= pdec_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    pass_d  = pass_q;
    keys_d  = keys_q;
    jdec_d  = jdec_q;
    sel_d   = sel_q;
    pdec_d  = pdec_q;
    perr_d  = 1'b0;
    cfg     = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          keys_d = in_key;
          jdec_d = in_decrypt;
          if (CHECK_PARITY && !parity_ok(in_key)) begin
            perr_d = 1'b1;
          end else begin
            cfg     = pass_cfg(2'd0, in_decrypt);
            state_d = RUN;
            pass_d  = 2'd0;
            round_d = 4'd0;
            sel_d   = cfg[1:0];
            pdec_d  = cfg[2];
            cd_d    = load_cd(get_key(in_key, cfg[1:0]), cfg[2]);
          end
        end
      end
      RUN: begin
        // Abort wins over a handshake in the same cycle.
        if (in_abort) begin
          state_d = IDLE;
        end else if (rk_ready) begin
          if (round_q == 4'd15) begin
            round_d = 4'd0;
            if (rk_last) begin
              state_d = IDLE;
            end else begin
              pass_d = pass_q + 2'd1;
              cfg    = pass_cfg(pass_q + 2'd1, jdec_q);
              sel_d  = cfg[1:0];
              pdec_d = cfg[2];
              cd_d   = load_cd(get_key(keys_q, cfg[1:0]), cfg[2]);
            end
          end else begin
            round_d = round_q + 4'd1;
            if (pdec_q)
              cd_d = {rotr(cd_q[55:28], SHIFT2[4'd15 - round_q]),
                      rotr(cd_q[27:0],  SHIFT2[4'd15 - round_q])};
            else
              cd_d = {rotl(cd_q[55:28], SHIFT2[round_q + 4'd1]),
                      rotl(cd_q[27:0],  SHIFT2[round_q + 4'd1])};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign rk_valid   = (state_q == RUN);
  assign rk_data    = pc2(cd_q);
  assign rk_round   = round_q;
  assign rk_key_sel = sel_q;
  assign rk_dec     = pdec_q;
  assign rk_last    = (pass_q == 2'(NUM_KEYS - 1)) && (round_q == 4'd15);
  assign parity_err = perr_q;

endmodule
